matvec_sequencer: RTL and testbench

// - Parametrised sequencer for the systolic matrix-vector array: CSR-programmed, drives memory addresses, array enable/clear and result readout.
// - Sits between the CSR bus and the PE array / operand memory; replaces the fixed-size controller.
// - New vs. previous generation:
//   - programmable base address;
//   - synchronous CSR handshake;
//   - abort command;
//   - done pulse and busy flag;
//   - size-error detection.

---
 rtl/matvec_pkg.sv | 20 ++
 rtl/matvec_addr_gen.sv | 39 +++
 rtl/matvec_sequencer.sv | 148 ++++++++++++++
 tb/tb_matvec_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matvec_pkg.sv
// Shared types and CSR encodings for the matrix-vector sequencer.
package matvec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    READ,
    DONE
  } state_t;

  localparam logic [1:0] CSR_SEL_ROWS = 2'd0;
  localparam logic [1:0] CSR_SEL_COLS = 2'd1;
  localparam logic [1:0] CSR_SEL_BASE = 2'd2;
  localparam logic [1:0] CSR_SEL_CTRL = 2'd3;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_ABORT_BIT = 1;

endpackage

// File: rtl/matvec_addr_gen.sv
// Registered per-PE matrix fetch addresses: BASE+ROWS+offset+i for active columns,
// the reserved zero word otherwise.
module matvec_addr_gen
  import matvec_pkg::*;
#(
  parameter int unsigned          ADDR_SIZE = 10,
  parameter int unsigned          PE_NUMBER = 64,
  parameter int unsigned          DIM_W     = 8,
  parameter logic [ADDR_SIZE-1:0] ZERO_ADDR = '1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_SIZE-1:0] base,
  input  logic [DIM_W-1:0]     rows,
  input  logic [DIM_W-1:0]     cols,
  input  logic [ADDR_SIZE-1:0] offset,
  input  logic                 fetch,
  output logic [ADDR_SIZE-1:0] pe_addr [PE_NUMBER]
);

  logic [ADDR_SIZE-1:0] row_base;
  logic [ADDR_SIZE-1:0] pe_nxt [PE_NUMBER];

  assign row_base = base + ADDR_SIZE'(rows) + offset;

  for (genvar g = 0; g < PE_NUMBER; g++) begin : g_pe
    localparam logic [DIM_W-1:0] IDX = DIM_W'(g);
    assign pe_nxt[g] = (fetch && (IDX < cols)) ? row_base + ADDR_SIZE'(g) : ZERO_ADDR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < PE_NUMBER; i++) pe_addr[i] <= ZERO_ADDR;
    end else begin
      for (int unsigned i = 0; i < PE_NUMBER; i++) pe_addr[i] <= pe_nxt[i];
    end
  end

endmodule

// File: rtl/matvec_sequencer.sv
// CSR-programmed sequencer for the systolic matrix-vector array: fetch addressing,
// array enable/clear, result readout, abort and size-error detection.
module matvec_sequencer
  import matvec_pkg::*;
#(
  parameter int unsigned          ADDR_SIZE    = 10,
  parameter int unsigned          PE_NUMBER    = 64,
  parameter int unsigned          DIM_W        = 8,
  parameter logic [15:0]          BASE_DEFAULT = 16'h000f,
  parameter logic [ADDR_SIZE-1:0] ZERO_ADDR    = '1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 csr_valid,
  output logic                 csr_ready,
  input  logic [1:0]           csr_sel,
  input  logic [15:0]          csr_data,
  output logic [ADDR_SIZE-1:0] vec_addr,
  output logic [ADDR_SIZE-1:0] pe_addr [PE_NUMBER],
  output logic                 array_clr,
  output logic                 array_en,
  output logic                 rd_en,
  output logic [DIM_W-1:0]     rd_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_t               state, state_nxt;
  logic [DIM_W-1:0]     cnt, cnt_nxt;
  logic [ADDR_SIZE-1:0] off, off_nxt;
  logic [DIM_W-1:0]     rows_q, cols_q;
  logic [ADDR_SIZE-1:0] base_q;
  logic                 err_nxt;
  logic                 csr_wr, start_cmd, abort_cmd, size_bad;

  assign csr_ready = 1'b1;
  assign csr_wr    = csr_valid && csr_ready;
  assign start_cmd = csr_wr && (csr_sel == CSR_SEL_CTRL) && csr_data[CTRL_START_BIT];
  assign abort_cmd = csr_wr && (csr_sel == CSR_SEL_CTRL) && csr_data[CTRL_ABORT_BIT];
  assign size_bad  = (rows_q == '0) || (cols_q == '0) || (32'(cols_q) > PE_NUMBER);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_q <= '0;
      cols_q <= '0;
      base_q <= ADDR_SIZE'(BASE_DEFAULT);
    end else if (csr_wr && (state == IDLE)) begin
      case (csr_sel)
        CSR_SEL_ROWS: rows_q <= DIM_W'(csr_data);
        CSR_SEL_COLS: cols_q <= DIM_W'(csr_data);
        CSR_SEL_BASE: base_q <= ADDR_SIZE'(csr_data);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    off_nxt   = off;
    err_nxt   = err;
    case (state)
      IDLE: begin
        if (start_cmd && !abort_cmd) begin
          if (size_bad) begin
            err_nxt = 1'b1;
          end else begin
            err_nxt   = 1'b0;
            state_nxt = FETCH;
            cnt_nxt   = '0;
            off_nxt   = '0;
          end
        end
      end
      FETCH: begin
        if (cnt == rows_q - DIM_W'(1)) begin
          cnt_nxt   = '0;
          state_nxt = (cols_q == DIM_W'(1)) ? READ : DRAIN;
        end else begin
          cnt_nxt = cnt + DIM_W'(1);
          off_nxt = off + ADDR_SIZE'(cols_q);
        end
      end
      DRAIN: begin
        if (cnt == cols_q - DIM_W'(2)) begin
          cnt_nxt   = '0;
          state_nxt = READ;
        end else begin
          cnt_nxt = cnt + DIM_W'(1);
        end
      end
      READ: begin
        if (cnt == cols_q - DIM_W'(1)) state_nxt = DONE;
        else                           cnt_nxt   = cnt + DIM_W'(1);
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_cmd) state_nxt = IDLE;
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      off       <= '0;
      vec_addr  <= ZERO_ADDR;
      array_clr <= 1'b1;
      array_en  <= 1'b0;
      rd_en     <= 1'b0;
      rd_idx    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      off       <= off_nxt;
      vec_addr  <= (state_nxt == FETCH) ? base_q + ADDR_SIZE'(cnt_nxt) : ZERO_ADDR;
      array_clr <= (state_nxt == IDLE);
      array_en  <= (state_nxt inside {FETCH, DRAIN});
      rd_en     <= (state_nxt == READ);
      rd_idx    <= (state_nxt == READ) ? cnt_nxt : '0;
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == DONE);
      err       <= err_nxt;
    end
  end

  matvec_addr_gen #(
    .ADDR_SIZE (ADDR_SIZE),
    .PE_NUMBER (PE_NUMBER),
    .DIM_W     (DIM_W),
    .ZERO_ADDR (ZERO_ADDR)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .base    (base_q),
    .rows    (rows_q),
    .cols    (cols_q),
    .offset  (off_nxt),
    .fetch   (state_nxt == FETCH),
    .pe_addr (pe_addr)
  );

endmodule

// File: tb/tb_matvec_sequencer.sv
// Scoreboard bench for matvec_sequencer with 4 PEs and 10-bit addresses.
module tb_matvec_sequencer;
  import matvec_pkg::*;

  localparam int unsigned AW  = 10;
  localparam int unsigned PEN = 4;
  localparam int unsigned DW  = 8;
  localparam logic [AW-1:0] Z = 10'h3FF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          csr_valid = 1'b0;
  logic          csr_ready;
  logic [1:0]    csr_sel = 2'd0;
  logic [15:0]   csr_data = 16'd0;
  logic [AW-1:0] vec_addr;
  logic [AW-1:0] pe_addr [PEN];
  logic          array_clr, array_en, rd_en, busy, done, err;
  logic [DW-1:0] rd_idx;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [9:0] vec, p0, p1, p2, p3;
    logic       en, rd;
    logic [7:0] idx;
    logic       dn;
  } rec_t;

  rec_t exp_q[$];
  rec_t nominal[7], rows4[8], cols4[9], wrap[4];

  matvec_sequencer #(
    .ADDR_SIZE    (AW),
    .PE_NUMBER    (PEN),
    .DIM_W        (DW),
    .BASE_DEFAULT (16'h000F),
    .ZERO_ADDR    (Z)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .csr_valid (csr_valid),
    .csr_ready (csr_ready),
    .csr_sel   (csr_sel),
    .csr_data  (csr_data),
    .vec_addr  (vec_addr),
    .pe_addr   (pe_addr),
    .array_clr (array_clr),
    .array_en  (array_en),
    .rd_en     (rd_en),
    .rd_idx    (rd_idx),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic rec_t mk(input logic [9:0] v, p0, p1, p2, p3,
                              input logic en, rd, input logic [7:0] idx, input logic dn);
    rec_t r;
    r.vec = v; r.p0 = p0; r.p1 = p1; r.p2 = p2; r.p3 = p3;
    r.en = en; r.rd = rd; r.idx = idx; r.dn = dn;
    return r;
  endfunction

  // Monitor: any non-idle output cycle must match the next expected record.
  always @(negedge clk) begin
    rec_t act, e;
    act = mk(vec_addr, pe_addr[0], pe_addr[1], pe_addr[2], pe_addr[3],
             array_en, rd_en, rd_idx, done);
    if (busy !== 1'b0 || done !== 1'b0 || array_en !== 1'b0 || rd_en !== 1'b0 ||
        array_clr !== 1'b1 || vec_addr !== Z || pe_addr[0] !== Z || pe_addr[1] !== Z ||
        pe_addr[2] !== Z || pe_addr[3] !== Z) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_activity t=%0t: got vec=%h pe=%h,%h,%h,%h en=%b rd=%b idx=%0d done=%b busy=%b clr=%b required idle",
                 $time, vec_addr, pe_addr[0], pe_addr[1], pe_addr[2], pe_addr[3],
                 array_en, rd_en, rd_idx, done, busy, array_clr);
      end else begin
        e = exp_q.pop_front();
        if (act !== e || busy !== 1'b1 || array_clr !== 1'b0) begin
          mismatched++;
          $display("FAIL trace t=%0t: got vec=%h pe=%h,%h,%h,%h en=%b rd=%b idx=%0d done=%b busy=%b clr=%b required vec=%h pe=%h,%h,%h,%h en=%b rd=%b idx=%0d done=%b busy=1 clr=0",
                   $time, act.vec, act.p0, act.p1, act.p2, act.p3, act.en, act.rd, act.idx, act.dn,
                   busy, array_clr, e.vec, e.p0, e.p1, e.p2, e.p3, e.en, e.rd, e.idx, e.dn);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    compared++;
    if (act !== ex) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h", nm, act, ex);
    end
  endtask

  task automatic csr_write(input logic [1:0] sel, input logic [15:0] data);
    @(negedge clk);
    csr_valid = 1'b1;
    csr_sel   = sel;
    csr_data  = data;
    @(negedge clk);
    csr_valid = 1'b0;
    csr_data  = 16'd0;
  endtask

  task automatic wait_idle(input string nm);
    int unsigned n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle"}, {31'd0, busy}, 32'd0);
    chk({nm, "_drained"}, exp_q.size(), 32'd0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_vec"}, vec_addr, Z);
    for (int i = 0; i < PEN; i++) chk({nm, "_pe"}, pe_addr[i], Z);
    chk({nm, "_clr"}, array_clr, 1);
    chk({nm, "_en"}, array_en, 0);
    chk({nm, "_rd"}, rd_en, 0);
    chk({nm, "_idx"}, rd_idx, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_ready"}, csr_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nominal[0] = mk(10'h00F, 10'h012, 10'h013, Z, Z, 1, 0, 0, 0);
    nominal[1] = mk(10'h010, 10'h014, 10'h015, Z, Z, 1, 0, 0, 0);
    nominal[2] = mk(10'h011, 10'h016, 10'h017, Z, Z, 1, 0, 0, 0);
    nominal[3] = mk(Z, Z, Z, Z, Z, 1, 0, 0, 0);
    nominal[4] = mk(Z, Z, Z, Z, Z, 0, 1, 0, 0);
    nominal[5] = mk(Z, Z, Z, Z, Z, 0, 1, 1, 0);
    nominal[6] = mk(Z, Z, Z, Z, Z, 0, 0, 0, 1);

    rows4[0] = mk(10'h00F, 10'h013, 10'h014, Z, Z, 1, 0, 0, 0);
    rows4[1] = mk(10'h010, 10'h015, 10'h016, Z, Z, 1, 0, 0, 0);
    rows4[2] = mk(10'h011, 10'h017, 10'h018, Z, Z, 1, 0, 0, 0);
    rows4[3] = mk(10'h012, 10'h019, 10'h01A, Z, Z, 1, 0, 0, 0);
    rows4[4] = mk(Z, Z, Z, Z, Z, 1, 0, 0, 0);
    rows4[5] = mk(Z, Z, Z, Z, Z, 0, 1, 0, 0);
    rows4[6] = mk(Z, Z, Z, Z, Z, 0, 1, 1, 0);
    rows4[7] = mk(Z, Z, Z, Z, Z, 0, 0, 0, 1);

    cols4[0] = mk(10'h00F, 10'h010, 10'h011, 10'h012, 10'h013, 1, 0, 0, 0);
    cols4[1] = mk(Z, Z, Z, Z, Z, 1, 0, 0, 0);
    cols4[2] = mk(Z, Z, Z, Z, Z, 1, 0, 0, 0);
    cols4[3] = mk(Z, Z, Z, Z, Z, 1, 0, 0, 0);
    cols4[4] = mk(Z, Z, Z, Z, Z, 0, 1, 0, 0);
    cols4[5] = mk(Z, Z, Z, Z, Z, 0, 1, 1, 0);
    cols4[6] = mk(Z, Z, Z, Z, Z, 0, 1, 2, 0);
    cols4[7] = mk(Z, Z, Z, Z, Z, 0, 1, 3, 0);
    cols4[8] = mk(Z, Z, Z, Z, Z, 0, 0, 0, 1);

    wrap[0] = mk(10'h3FE, 10'h000, Z, Z, Z, 1, 0, 0, 0);
    wrap[1] = mk(10'h3FF, 10'h001, Z, Z, Z, 1, 0, 0, 0);
    wrap[2] = mk(Z, Z, Z, Z, Z, 0, 1, 0, 0);
    wrap[3] = mk(Z, Z, Z, Z, Z, 0, 0, 0, 1);

    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    reset = 1'b0;

    // Size errors and their clearing by a valid start.
    csr_write(CSR_SEL_COLS, 16'd5);
    csr_write(CSR_SEL_ROWS, 16'd3);
    csr_write(CSR_SEL_CTRL, 16'h0001);
    chk("err_cols5", err, 1);
    chk("busy_cols5", busy, 0);
    csr_write(CSR_SEL_COLS, 16'd2);
    foreach (nominal[i]) exp_q.push_back(nominal[i]);
    csr_write(CSR_SEL_CTRL, 16'h0001);
    chk("err_clear1", err, 0);
    wait_idle("nominal1");
    csr_write(CSR_SEL_ROWS, 16'd0);
    csr_write(CSR_SEL_CTRL, 16'h0001);
    chk("err_rows0", err, 1);
    chk("busy_rows0", busy, 0);

    // COLS equal to PE count is legal.
    csr_write(CSR_SEL_ROWS, 16'd1);
    csr_write(CSR_SEL_COLS, 16'd4);
    foreach (cols4[i]) exp_q.push_back(cols4[i]);
    csr_write(CSR_SEL_CTRL, 16'h0001);
    chk("err_clear2", err, 0);
    wait_idle("cols4");

    // Abort and start together: abort wins.
    csr_write(CSR_SEL_ROWS, 16'd3);
    csr_write(CSR_SEL_COLS, 16'd2);
    csr_write(CSR_SEL_CTRL, 16'h0003);
    chk("abort_start_busy", busy, 0);

    // Abort during DRAIN, then immediate restart.
    for (int i = 0; i < 4; i++) exp_q.push_back(nominal[i]);
    csr_write(CSR_SEL_CTRL, 16'h0001);
    repeat (2) @(negedge clk);
    csr_write(CSR_SEL_CTRL, 16'h0002);
    chk("abort_clr", array_clr, 1);
    chk("abort_en", array_en, 0);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_err", err, 0);
    chk("abort_left", exp_q.size(), 0);
    foreach (nominal[i]) exp_q.push_back(nominal[i]);
    csr_write(CSR_SEL_CTRL, 16'h0001);
    wait_idle("restart");

    // Writes while busy are ignored.
    foreach (nominal[i]) exp_q.push_back(nominal[i]);
    csr_write(CSR_SEL_CTRL, 16'h0001);
    csr_write(CSR_SEL_ROWS, 16'd5);
    csr_write(CSR_SEL_BASE, 16'h0100);
    csr_write(CSR_SEL_CTRL, 16'h0001);
    wait_idle("busywr");
    foreach (nominal[i]) exp_q.push_back(nominal[i]);
    csr_write(CSR_SEL_CTRL, 16'h0001);
    wait_idle("after_busywr");
    csr_write(CSR_SEL_ROWS, 16'd4);
    foreach (rows4[i]) exp_q.push_back(rows4[i]);
    csr_write(CSR_SEL_CTRL, 16'h0001);
    wait_idle("rows4");

    // Address wrap, interrupted by an asynchronous reset during READ.
    csr_write(CSR_SEL_BASE, 16'h03FE);
    csr_write(CSR_SEL_ROWS, 16'd2);
    csr_write(CSR_SEL_COLS, 16'd1);
    for (int i = 0; i < 2; i++) exp_q.push_back(wrap[i]);
    csr_write(CSR_SEL_CTRL, 16'h0001);
    repeat (2) @(posedge clk);
    #2;
    chk("wrap_in_read", rd_en, 1);
    reset = 1'b1;
    #1;
    chk_reset_vals("async");
    #1;
    reset = 1'b0;
    chk("wrap_left", exp_q.size(), 0);

    // BASE must be back at its default after reset.
    csr_write(CSR_SEL_ROWS, 16'd3);
    csr_write(CSR_SEL_COLS, 16'd2);
    foreach (nominal[i]) exp_q.push_back(nominal[i]);
    csr_write(CSR_SEL_CTRL, 16'h0001);
    wait_idle("post_reset");

    repeat (3) @(negedge clk);
    chk("final_queue", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
